// File: rtl/grayblast_pkg.sv
// Shared constants and types for the shader instruction sequencer.
package grayblast_pkg;

    localparam int OPCODE_W   = 14;
    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int LEN_W      = ADDR_W + 1;

    localparam logic [OPCODE_W-1:0] OPC_HALT  = 14'h3FFF;
    localparam logic [LEN_W-1:0]    DEPTH_LEN = LEN_W'(PROG_DEPTH);

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    function automatic logic is_halt(input logic [OPCODE_W-1:0] op);
        return (op == OPC_HALT);
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no storage reset.
module seq_prog_mem #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/core_sequencer.sv
// Loads a short shader program over a valid/ready stream and replays it, one opcode
// per clock, to the GPU cores on every start pulse.
module core_sequencer
    import grayblast_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_valid,
    output logic                prog_ready,
    input  logic [OPCODE_W-1:0] prog_data,
    input  logic                prog_last,
    input  logic                start,
    output logic [OPCODE_W-1:0] opcode,
    output logic                execute,
    output logic                busy,
    output logic                done,
    output logic                prog_err
);

    seq_state_t          state_r;
    logic [LEN_W-1:0]    pc_r;
    logic [LEN_W-1:0]    wr_ptr_r;
    logic [LEN_W-1:0]    prog_len_r;
    logic                load_active_r;
    logic [OPCODE_W-1:0] opcode_r;
    logic                execute_r;
    logic                busy_r;
    logic                done_r;
    logic                prog_err_r;

    logic                prog_ready_s;
    logic                accept_s;
    logic                mem_we_s;
    logic                start_ok_s;
    logic                run_end_s;
    logic [OPCODE_W-1:0] rd_data_s;

    seq_prog_mem #(
        .WIDTH (OPCODE_W),
        .DEPTH (PROG_DEPTH),
        .AW    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (prog_data),
        .raddr (pc_r[ADDR_W-1:0]),
        .rdata (rd_data_s)
    );

    // Handshake and run-control decodes; start wins a tie with an offered word
    always_comb begin
        prog_ready_s = 1'b0;
        if ((state_r == SEQ_IDLE) && !start) begin
            prog_ready_s = 1'b1;
        end else begin
            prog_ready_s = 1'b0;
        end
        accept_s   = prog_valid & prog_ready_s;
        mem_we_s   = accept_s & (wr_ptr_r < DEPTH_LEN);
        start_ok_s = start & (state_r == SEQ_IDLE) & ~load_active_r;
        run_end_s  = (pc_r == prog_len_r) | is_halt(rd_data_s);
    end

    // Program loading: write pointer, committed length, overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= {LEN_W{1'b0}};
            prog_len_r    <= {LEN_W{1'b0}};
            load_active_r <= 1'b0;
            prog_err_r    <= 1'b0;
        end else if (accept_s) begin
            if (wr_ptr_r == DEPTH_LEN) begin
                prog_err_r <= 1'b1;
            end
            if (prog_last) begin
                // wr_ptr saturates at DEPTH_LEN, so this clamps the length too
                prog_len_r    <= (wr_ptr_r == DEPTH_LEN) ? DEPTH_LEN : (wr_ptr_r + 5'd1);
                wr_ptr_r      <= {LEN_W{1'b0}};
                load_active_r <= 1'b0;
            end else begin
                wr_ptr_r      <= (wr_ptr_r == DEPTH_LEN) ? DEPTH_LEN : (wr_ptr_r + 5'd1);
                load_active_r <= 1'b1;
            end
        end
    end

    // Run FSM with registered core-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= SEQ_IDLE;
            pc_r      <= {LEN_W{1'b0}};
            opcode_r  <= {OPCODE_W{1'b0}};
            execute_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            execute_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    if (start_ok_s) begin
                        if ((prog_len_r == {LEN_W{1'b0}}) || is_halt(rd_data_s)) begin
                            done_r <= 1'b1;
                        end else begin
                            opcode_r  <= rd_data_s;
                            execute_r <= 1'b1;
                            busy_r    <= 1'b1;
                            pc_r      <= 5'd1;
                            state_r   <= SEQ_RUN;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (run_end_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        pc_r    <= {LEN_W{1'b0}};
                        state_r <= SEQ_IDLE;
                    end else begin
                        opcode_r  <= rd_data_s;
                        execute_r <= 1'b1;
                        pc_r      <= pc_r + 5'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    pc_r    <= {LEN_W{1'b0}};
                    state_r <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign prog_ready = prog_ready_s;
    assign opcode     = opcode_r;
    assign execute    = execute_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign prog_err   = prog_err_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: load/replay, HALT, overflow, ignored starts, reset.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_valid = 1'b0;
    logic        prog_last = 1'b0;
    logic        start = 1'b0;
    logic [13:0] prog_data = 14'h0000;
    logic        prog_ready;
    logic [13:0] opcode;
    logic        execute;
    logic        busy;
    logic        done;
    logic        prog_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [13:0] ld_a  [20];
    logic [31:0] exp_a [20];

    core_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .start      (start),
        .opcode     (opcode),
        .execute    (execute),
        .busy       (busy),
        .done       (done),
        .prog_err   (prog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            prog_valid = 1'b1;
            prog_data  = ld_a[i];
            prog_last  = with_last && (i == n - 1);
            tick();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    // Pulses start, then expects n issued opcodes from exp_a followed by one done cycle
    task automatic run_expect(input int n, input bit mid_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("exec", 32'(execute), 32'd1);
            check("opcode", 32'(opcode), exp_a[k]);
            check("busy", 32'(busy), 32'd1);
            check("done_lo", 32'(done), 32'd0);
            if (mid_start && k == 0) begin
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("exec_end", 32'(execute), 32'd0);
        check("done", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        if (n > 0) begin
            check("opc_hold", 32'(opcode), exp_a[n-1]);
        end
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("exec_after", 32'(execute), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_exec", 32'(execute), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(prog_err), 32'd0);
        check("rst_ready", 32'(prog_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Empty program: done only
        run_expect(0, 1'b0);

        // Basic three-word program
        ld_a[0] = 14'h0011; ld_a[1] = 14'h0022; ld_a[2] = 14'h0033;
        load_prog(3, 1'b1);
        exp_a[0] = 32'h0011; exp_a[1] = 32'h0022; exp_a[2] = 32'h0033;
        run_expect(3, 1'b0);

        // HALT stops the run early
        ld_a[0] = 14'h0100; ld_a[1] = 14'h3FFF; ld_a[2] = 14'h0200;
        load_prog(3, 1'b1);
        exp_a[0] = 32'h0100;
        run_expect(1, 1'b0);
        check("err_clear", 32'(prog_err), 32'd0);

        // Overflow: 20 words, only the first 16 kept
        for (int i = 0; i < 20; i++) begin
            ld_a[i]  = 14'h1000 + 14'(i);
            exp_a[i] = 32'h1000 + 32'(i);
        end
        load_prog(20, 1'b1);
        check("err_set", 32'(prog_err), 32'd1);
        run_expect(16, 1'b0);

        // Start during RUN ignored
        ld_a[0] = 14'h00A1; ld_a[1] = 14'h00A2; ld_a[2] = 14'h00A3;
        load_prog(3, 1'b1);
        exp_a[0] = 32'h00A1; exp_a[1] = 32'h00A2; exp_a[2] = 32'h00A3;
        run_expect(3, 1'b1);
        check("err_sticky", 32'(prog_err), 32'd1);

        // Start mid-load ignored
        ld_a[0] = 14'h00B1; ld_a[1] = 14'h00B2;
        load_prog(2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midload_exec", 32'(execute), 32'd0);
        check("midload_busy", 32'(busy), 32'd0);
        check("midload_done", 32'(done), 32'd0);
        tick();
        check("midload_done2", 32'(done), 32'd0);
        prog_valid = 1'b1; prog_data = 14'h00B3; prog_last = 1'b1;
        tick();
        prog_valid = 1'b0; prog_last = 1'b0;
        exp_a[0] = 32'h00B1; exp_a[1] = 32'h00B2; exp_a[2] = 32'h00B3;
        run_expect(3, 1'b0);

        // start and prog_valid in the same cycle: word waits until the run ends
        prog_valid = 1'b1; prog_data = 14'h0555; prog_last = 1'b1; start = 1'b1;
        #1;
        check("tie_ready", 32'(prog_ready), 32'd0);
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("tie_exec", 32'(execute), 32'd1);
            check("tie_opcode", 32'(opcode), exp_a[k]);
            check("tie_ready_run", 32'(prog_ready), 32'd0);
            tick();
        end
        check("tie_done", 32'(done), 32'd1);
        check("tie_ready_done", 32'(prog_ready), 32'd1);
        tick();
        prog_valid = 1'b0; prog_last = 1'b0;

        // Back-to-back runs: start in the done cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_exec1", 32'(execute), 32'd1);
        check("b2b_opc1", 32'(opcode), 32'h0555);
        tick();
        check("b2b_done1", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_exec2", 32'(execute), 32'd1);
        check("b2b_opc2", 32'(opcode), 32'h0555);
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_done_lo", 32'(done), 32'd0);
        tick();
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_exec_end", 32'(execute), 32'd0);
        tick();

        // Reset mid-RUN
        ld_a[0] = 14'h0C01; ld_a[1] = 14'h0C02; ld_a[2] = 14'h0C03;
        load_prog(3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("prerst_exec", 32'(execute), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_exec", 32'(execute), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_opc", 32'(opcode), 32'd0);
        check("midrst_err", 32'(prog_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_expect(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
